// File: rtl/mag_peak_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mag_peak_pkg : shared types and constants for the frame peak detector
// Revision 1.0
// ---------------------------------------------------------------------------
package mag_peak_pkg;

  localparam int DATA_LEN_DEF  = 64;
  localparam int TUSER_LEN_DEF = 32;
  localparam int IDX_LEN_DEF   = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_e;

  localparam logic [IDX_LEN_DEF-1:0] IDX_SAT  = '1;
  localparam logic [15:0]            DROP_SAT = 16'hFFFF;

  // Result record at the default widths, for consumers of the packed output
  typedef struct packed {
    logic [DATA_LEN_DEF-1:0]  peak;
    logic [IDX_LEN_DEF-1:0]   index;
    logic [IDX_LEN_DEF-1:0]   len;
    logic [TUSER_LEN_DEF-1:0] tuser;
    logic                     ovf;
`ifdef MAG_PEAK_THRESH_EN
    logic [IDX_LEN_DEF-1:0]   above_cnt;
    logic [IDX_LEN_DEF-1:0]   first_above;
`endif
  } peak_rec_t;

endpackage
`default_nettype wire

// File: rtl/mag_peak_hold.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mag_peak_hold : single-entry valid/ready result register with drop counter
// Revision 1.0
// ---------------------------------------------------------------------------
module mag_peak_hold
  import mag_peak_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [15:0]  drop_count_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [15:0]  drop_q, drop_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = drop_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
    // A handshake in the same cycle frees the slot for the new record
    if (push_i) begin
      if (!valid_q || ready_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else if (drop_q != DROP_SAT) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign drop_count_o = drop_q;

endmodule
`default_nettype wire

// File: rtl/mag_peak_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mag_peak_detect : per-frame peak search over a squared-magnitude stream
// Optional threshold statistics enabled by MAG_PEAK_THRESH_EN. Revision 1.0
// ---------------------------------------------------------------------------
module mag_peak_detect
  import mag_peak_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int TUSER_LEN = TUSER_LEN_DEF,
  parameter int IDX_LEN   = IDX_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [DATA_LEN-1:0]  s_mag_tdata,
  input  logic                 s_mag_tvalid,
  input  logic                 s_mag_tlast,
  input  logic [TUSER_LEN-1:0] s_mag_tuser,
  input  logic                 s_mag_overflow,
`ifdef MAG_PEAK_THRESH_EN
  input  logic [DATA_LEN-1:0]  thresh,
  output logic [IDX_LEN-1:0]   m_peak_above_cnt,
  output logic [IDX_LEN-1:0]   m_peak_first_above,
`endif
  output logic [DATA_LEN-1:0]  m_peak_tdata,
  output logic [IDX_LEN-1:0]   m_peak_index,
  output logic [IDX_LEN-1:0]   m_peak_frame_len,
  output logic [TUSER_LEN-1:0] m_peak_tuser,
  output logic                 m_peak_ovf,
  output logic                 m_peak_tvalid,
  input  logic                 m_peak_tready,
  output logic [15:0]          drop_count
);

  localparam logic [IDX_LEN-1:0] IDX_ONES = '1;

  typedef struct packed {
    logic [DATA_LEN-1:0]  peak;
    logic [IDX_LEN-1:0]   index;
    logic [IDX_LEN-1:0]   len;
    logic [TUSER_LEN-1:0] tuser;
    logic                 ovf;
`ifdef MAG_PEAK_THRESH_EN
    logic [IDX_LEN-1:0]   above_cnt;
    logic [IDX_LEN-1:0]   first_above;
`endif
  } rec_t;

  state_e               state_q, state_d;
  logic [DATA_LEN-1:0]  max_q, max_d;
  logic [IDX_LEN-1:0]   max_idx_q, max_idx_d;
  logic [IDX_LEN-1:0]   cnt_q, cnt_d;
  logic [TUSER_LEN-1:0] tuser_q, tuser_d;
  logic                 ovf_q, ovf_d;
`ifdef MAG_PEAK_THRESH_EN
  logic [IDX_LEN-1:0]   above_q, above_d;
  logic [IDX_LEN-1:0]   first_q, first_d;
  logic                 sample_ge;
`endif

  logic [DATA_LEN-1:0]  sample;
  logic [IDX_LEN-1:0]   cnt_inc;
  logic                 push;
  rec_t                 rec_in, rec_out;

  assign sample  = s_mag_overflow ? {DATA_LEN{1'b1}} : s_mag_tdata;
  // cnt_q is both the index of the incoming beat and the beats seen so far
  assign cnt_inc = (cnt_q == IDX_ONES) ? cnt_q : cnt_q + IDX_LEN'(1);
`ifdef MAG_PEAK_THRESH_EN
  assign sample_ge = (sample >= thresh);
`endif

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    cnt_d     = cnt_q;
    tuser_d   = tuser_q;
    ovf_d     = ovf_q;
`ifdef MAG_PEAK_THRESH_EN
    above_d   = above_q;
    first_d   = first_q;
`endif
    push      = 1'b0;
    if (s_mag_tvalid) begin
      if (state_q == ST_IDLE) begin
        max_d     = sample;
        max_idx_d = '0;
        cnt_d     = IDX_LEN'(1);
        tuser_d   = s_mag_tuser;
        ovf_d     = s_mag_overflow;
`ifdef MAG_PEAK_THRESH_EN
        above_d   = sample_ge ? IDX_LEN'(1) : '0;
        first_d   = sample_ge ? '0 : IDX_ONES;
`endif
      end else begin
        if (sample > max_q) begin
          max_d     = sample;
          max_idx_d = cnt_q;
        end
        cnt_d = cnt_inc;
        ovf_d = ovf_q | s_mag_overflow;
`ifdef MAG_PEAK_THRESH_EN
        if (sample_ge) begin
          if (above_q != IDX_ONES) above_d = above_q + IDX_LEN'(1);
          if (above_q == '0)       first_d = cnt_q;
        end
`endif
      end
      state_d = s_mag_tlast ? ST_IDLE : ST_FRAME;
      push    = s_mag_tlast;
    end
  end

  always_comb begin
    rec_in       = '0;
    rec_in.peak  = max_d;
    rec_in.index = max_idx_d;
    rec_in.len   = cnt_d;
    rec_in.tuser = tuser_d;
    rec_in.ovf   = ovf_d;
`ifdef MAG_PEAK_THRESH_EN
    rec_in.above_cnt   = above_d;
    rec_in.first_above = first_d;
`endif
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      max_q     <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
      tuser_q   <= '0;
      ovf_q     <= 1'b0;
`ifdef MAG_PEAK_THRESH_EN
      above_q   <= '0;
      first_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      cnt_q     <= cnt_d;
      tuser_q   <= tuser_d;
      ovf_q     <= ovf_d;
`ifdef MAG_PEAK_THRESH_EN
      above_q   <= above_d;
      first_q   <= first_d;
`endif
    end
  end

  mag_peak_hold #(
    .W ($bits(rec_t))
  ) u_hold (
    .clk          (clk),
    .aresetn      (aresetn),
    .push_i       (push),
    .data_i       (rec_in),
    .ready_i      (m_peak_tready),
    .valid_o      (m_peak_tvalid),
    .data_o       (rec_out),
    .drop_count_o (drop_count)
  );

  assign m_peak_tdata     = rec_out.peak;
  assign m_peak_index     = rec_out.index;
  assign m_peak_frame_len = rec_out.len;
  assign m_peak_tuser     = rec_out.tuser;
  assign m_peak_ovf       = rec_out.ovf;
`ifdef MAG_PEAK_THRESH_EN
  assign m_peak_above_cnt   = rec_out.above_cnt;
  assign m_peak_first_above = rec_out.first_above;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mag_peak_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mag_peak_detect : directed vector bench for mag_peak_detect
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mag_peak_detect;

  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [63:0] s_mag_tdata;
  logic        s_mag_tvalid;
  logic        s_mag_tlast;
  logic [31:0] s_mag_tuser;
  logic        s_mag_overflow;
  logic [63:0] m_peak_tdata;
  logic [15:0] m_peak_index;
  logic [15:0] m_peak_frame_len;
  logic [31:0] m_peak_tuser;
  logic        m_peak_ovf;
  logic        m_peak_tvalid;
  logic        m_peak_tready;
  logic [15:0] drop_count;
`ifdef MAG_PEAK_THRESH_EN
  logic [63:0] thresh;
  logic [15:0] m_peak_above_cnt;
  logic [15:0] m_peak_first_above;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mag_peak_detect dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .s_mag_tdata      (s_mag_tdata),
    .s_mag_tvalid     (s_mag_tvalid),
    .s_mag_tlast      (s_mag_tlast),
    .s_mag_tuser      (s_mag_tuser),
    .s_mag_overflow   (s_mag_overflow),
`ifdef MAG_PEAK_THRESH_EN
    .thresh             (thresh),
    .m_peak_above_cnt   (m_peak_above_cnt),
    .m_peak_first_above (m_peak_first_above),
`endif
    .m_peak_tdata     (m_peak_tdata),
    .m_peak_index     (m_peak_index),
    .m_peak_frame_len (m_peak_frame_len),
    .m_peak_tuser     (m_peak_tuser),
    .m_peak_ovf       (m_peak_ovf),
    .m_peak_tvalid    (m_peak_tvalid),
    .m_peak_tready    (m_peak_tready),
    .drop_count       (drop_count)
  );

  typedef struct {
    int          n;
    logic [63:0] d [6];
    logic [5:0]  ov;
    logic [31:0] user;
    logic [63:0] e_peak;
    logic [15:0] e_idx;
    logic [15:0] e_len;
    logic        e_ovf;
    logic [15:0] e_above;
    logic [15:0] e_first;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3,
                              input logic [63:0] d4, input logic [5:0] ov,
                              input logic [31:0] user, input logic [63:0] ep,
                              input logic [15:0] ei, input logic [15:0] el, input logic eo,
                              input logic [15:0] ea, input logic [15:0] ef);
    vec_t v;
    v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4; v.d[5] = '0;
    v.ov = ov; v.user = user;
    v.e_peak = ep; v.e_idx = ei; v.e_len = el; v.e_ovf = eo;
    v.e_above = ea; v.e_first = ef;
    return v;
  endfunction

  task automatic beat(input logic [63:0] d, input logic last, input logic ov, input logic [31:0] u);
    s_mag_tdata    = d;
    s_mag_tvalid   = 1'b1;
    s_mag_tlast    = last;
    s_mag_overflow = ov;
    s_mag_tuser    = u;
    @(posedge clk); #1;
    s_mag_tvalid   = 1'b0;
    s_mag_tlast    = 1'b0;
    s_mag_overflow = 1'b0;
  endtask

  // Frame with a tvalid=0/tlast=1 gap after its first beat; tuser varies per beat
  task automatic run_frame(input int k);
    vec_t v;
    v = vecs[k];
    for (int i = 0; i < v.n; i++) begin
      if (i == v.n - 1) chk($sformatf("v%0d_pre_valid", k), m_peak_tvalid, 1'b0);
      beat(v.d[i], i == v.n - 1, v.ov[i], (i == 0) ? v.user : ~v.user);
      if (i == 0 && v.n > 1) begin
        s_mag_tdata = 64'hDEAD;
        s_mag_tlast = 1'b1;
        @(posedge clk); #1;
        s_mag_tlast = 1'b0;
      end
    end
    chk($sformatf("v%0d_valid", k), m_peak_tvalid, 1'b1);
    chk($sformatf("v%0d_peak", k), m_peak_tdata, v.e_peak);
    chk($sformatf("v%0d_index", k), m_peak_index, v.e_idx);
    chk($sformatf("v%0d_len", k), m_peak_frame_len, v.e_len);
    chk($sformatf("v%0d_tuser", k), m_peak_tuser, v.user);
    chk($sformatf("v%0d_ovf", k), m_peak_ovf, v.e_ovf);
`ifdef MAG_PEAK_THRESH_EN
    chk($sformatf("v%0d_above", k), m_peak_above_cnt, v.e_above);
    chk($sformatf("v%0d_first", k), m_peak_first_above, v.e_first);
`endif
    @(posedge clk); #1;
    chk($sformatf("v%0d_cleared", k), m_peak_tvalid, 1'b0);
  endtask

  initial begin
    vecs[0] = mk(5, 10, 40, 25, 40, 5, 6'b000000, 32'hA1, 40, 1, 5, 1'b0, 3, 1);
    vecs[1] = mk(1, 7, 0, 0, 0, 0, 6'b000000, 32'hB2, 7, 0, 1, 1'b0, 0, 16'hFFFF);
    vecs[2] = mk(2, 3, 9, 0, 0, 0, 6'b000010, 32'hC3, ONES64, 1, 2, 1'b1, 1, 1);
    vecs[3] = mk(3, 5, 5, 5, 0, 0, 6'b000000, 32'hD4, 5, 0, 3, 1'b0, 0, 16'hFFFF);
    vecs[4] = mk(2, 100, 50, 0, 0, 0, 6'b000000, 32'hE5, 100, 0, 2, 1'b0, 2, 0);
    vecs[5] = mk(2, 1, 2, 0, 0, 0, 6'b000001, 32'hF6, ONES64, 0, 2, 1'b1, 1, 0);
    vecs[6] = mk(4, 10, 30, 20, 5, 0, 6'b000000, 32'h17, 30, 1, 4, 1'b0, 2, 1);
    vecs[7] = mk(2, 1, 2, 0, 0, 0, 6'b000000, 32'h28, 2, 1, 2, 1'b0, 0, 16'hFFFF);

    aresetn        = 1'b0;
    s_mag_tdata    = '0;
    s_mag_tvalid   = 1'b0;
    s_mag_tlast    = 1'b0;
    s_mag_tuser    = '0;
    s_mag_overflow = 1'b0;
    m_peak_tready  = 1'b1;
`ifdef MAG_PEAK_THRESH_EN
    thresh         = 64'd20;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", m_peak_tvalid, 1'b0);
    chk("rst_peak", m_peak_tdata, 64'd0);
    chk("rst_drop", drop_count, 16'd0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_frame(k);

    // Backpressure: second record is dropped, first held unchanged
    m_peak_tready = 1'b0;
    beat(1, 0, 0, 32'h11); beat(2, 0, 0, 0); beat(3, 0, 0, 0); beat(4, 1, 0, 0);
    chk("bp_a_valid", m_peak_tvalid, 1'b1);
    chk("bp_a_peak", m_peak_tdata, 64'd4);
    beat(9, 0, 0, 32'h22); beat(8, 0, 0, 0); beat(7, 0, 0, 0); beat(6, 1, 0, 0);
    chk("bp_hold_valid", m_peak_tvalid, 1'b1);
    chk("bp_hold_peak", m_peak_tdata, 64'd4);
    chk("bp_hold_index", m_peak_index, 16'd3);
    chk("bp_hold_len", m_peak_frame_len, 16'd4);
    chk("bp_hold_tuser", m_peak_tuser, 32'h11);
    chk("bp_drop", drop_count, 16'd1);
    m_peak_tready = 1'b1;
    @(posedge clk); #1;
    chk("bp_cleared_valid", m_peak_tvalid, 1'b0);
    chk("bp_cleared_peak", m_peak_tdata, 64'd0);

    // Reset mid-frame with a pending record
    m_peak_tready = 1'b0;
    beat(33, 1, 0, 32'h33);
    beat(50, 0, 0, 32'h99); beat(60, 0, 0, 0); beat(70, 0, 0, 0);
    #2 aresetn = 1'b0;
    #1;
    chk("mrst_valid", m_peak_tvalid, 1'b0);
    chk("mrst_peak", m_peak_tdata, 64'd0);
    chk("mrst_tuser", m_peak_tuser, 32'd0);
    chk("mrst_drop", drop_count, 16'd0);
    @(posedge clk); #1;
    chk("mrst_len", m_peak_frame_len, 16'd0);
    aresetn = 1'b1;
    m_peak_tready = 1'b1;
    @(posedge clk); #1;
    beat(2, 0, 0, 32'h44); beat(8, 1, 0, 0);
    chk("post_rst_valid", m_peak_tvalid, 1'b1);
    chk("post_rst_peak", m_peak_tdata, 64'd8);
    chk("post_rst_index", m_peak_index, 16'd1);
    chk("post_rst_len", m_peak_frame_len, 16'd2);
    chk("post_rst_tuser", m_peak_tuser, 32'h44);
    @(posedge clk); #1;

    // Handshake coincides with completion: new record replaces old, no drop
    m_peak_tready = 1'b0;
    beat(1, 0, 0, 32'h55); beat(2, 0, 0, 0); beat(3, 0, 0, 0); beat(4, 1, 0, 0);
    beat(9, 0, 0, 32'h66); beat(8, 0, 0, 0); beat(7, 0, 0, 0);
    m_peak_tready = 1'b1;
    beat(6, 1, 0, 0);
    m_peak_tready = 1'b0;
    chk("pulse_valid", m_peak_tvalid, 1'b1);
    chk("pulse_peak", m_peak_tdata, 64'd9);
    chk("pulse_index", m_peak_index, 16'd0);
    chk("pulse_tuser", m_peak_tuser, 32'h66);
    chk("pulse_drop", drop_count, 16'd0);
    m_peak_tready = 1'b1;
    @(posedge clk); #1;
    chk("pulse_cleared", m_peak_tvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mag_peak_detect.md
Name: mag_peak_detect

Overview:
- Downstream consumer of the squared-magnitude stream from the I/Q magnitude stage.
- Scans each tlast-delimited frame (one GPR range profile) for its largest squared-magnitude sample.
- Emits one result record per frame: peak value, peak index, frame length, first-beat tuser and overflow flag.
- Upstream has no backpressure; the result side uses a valid/ready handshake with a single holding register.

Parameters:
- DATA_LEN, 64, width of the squared-magnitude sample.
- TUSER_LEN, 32, width of sideband tuser.
- IDX_LEN, 16, width of sample index and frame-length counters.

Ports:
- clk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- s_mag_tdata  in  DATA_LEN  squared magnitude sample
- s_mag_tvalid  in  1  sample valid; no tready, every valid beat must be accepted
- s_mag_tlast  in  1  last sample of frame, qualified by tvalid
- s_mag_tuser  in  TUSER_LEN  sideband, sampled on first beat of frame
- s_mag_overflow  in  1  upstream sum overflow for this beat
- m_peak_tdata  out  DATA_LEN  frame peak value
- m_peak_index  out  IDX_LEN  index of peak within frame (0-based)
- m_peak_frame_len  out  IDX_LEN  number of beats in frame (saturating)
- m_peak_tuser  out  TUSER_LEN  tuser of first beat of frame
- m_peak_ovf  out  1  any beat in frame had s_mag_overflow
- m_peak_tvalid  out  1  result valid
- m_peak_tready  in  1  downstream accepts result
- drop_count  out  16  saturating count of results lost because the holding register was full

Behaviour:
- Reset (aresetn=0, async): all outputs 0, state ST_IDLE, counters 0, holding register empty.
- Effective sample: if s_mag_overflow=1, the sample is treated as all-ones (saturate); otherwise it is s_mag_tdata.
- ST_IDLE, valid beat:
  - load running max = sample, max_idx=0, idx=1, frame_len=1, capture tuser, ovf=overflow.
  - go to ST_FRAME, unless tlast is set, in which case complete the frame and stay in ST_IDLE.
- ST_FRAME, valid beat:
  - if sample > running max (strict, so the first occurrence wins ties), update max and max_idx=idx.
  - idx and frame_len increment and saturate at 2^IDX_LEN-1; once saturated, later beats keep their index at the saturated value (still eligible for max).
  - ovf is ORed with the beat's overflow.
  - tlast completes the frame and returns to ST_IDLE.
- Frame completion:
  - the final record includes the tlast beat.
  - it is written to the holding register on the clock edge of the tlast beat, so m_peak_tvalid rises 1 cycle after the tlast beat.
- Holding register:
  - m_peak_* stay stable while tvalid=1 and tready=0; cleared on a tvalid&tready handshake.
  - completion while full with no handshake that cycle: new record discarded, old kept, drop_count increments (saturates at 16'hFFFF).
  - completion in the same cycle as a handshake: new record loaded, no drop, tvalid stays 1.
- tvalid=0 beats: no state change; gaps within a frame are allowed.
- tlast with tvalid=0 is ignored.
- Reset mid-frame discards the partial frame; the next valid beat starts a new frame.

Optional Feature:
- MAG_PEAK_THRESH_EN defined:
  - adds input thresh (DATA_LEN) and outputs m_peak_above_cnt (IDX_LEN) and m_peak_first_above (IDX_LEN).
  - m_peak_above_cnt counts beats with effective sample >= thresh, saturating.
  - m_peak_first_above is the index of the first such beat, all-ones if none.
  - both are registered with the record and follow the same drop and handshake rules.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package mag_peak_pkg:
  - state enum {ST_IDLE, ST_FRAME}
  - IDX_SAT constant (all-ones of IDX_LEN)
  - DROP_SAT constant (16'hFFFF)
  - result record struct (peak, index, len, tuser, ovf, and threshold fields under the macro)
- One sub-module, mag_peak_hold: single-entry valid/ready holding register with the drop-counting rule.
- Scan and state logic stay in the top.

Test Plan:
- Frame 10,40,25,40,5 with tlast on 5 and tready=1 → one record: peak 40, index 1, len 5, m_peak_tvalid 1 cycle after the tlast beat.
- Single beat 7 with tvalid&tlast while ST_IDLE → peak 7, index 0, len 1; tuser of that beat passed through.
- Beat with s_mag_overflow=1 inside frame 3,9 → peak all-ones, index 1, m_peak_ovf=1.
- tready=0, two 4-beat frames back to back → first record held unchanged, second dropped, drop_count=1; same again but tready pulsed on the second frame's completion cycle → second record loaded, drop_count=0.
- aresetn asserted after beat 3 of a frame, released, then frame 2,8,tlast → peak 8, index 1, len 2; all outputs 0 during reset.
- With MAG_PEAK_THRESH_EN, thresh=20, frame 10,30,20,5 → above_cnt 2, first_above 1; frame 1,2 → above_cnt 0, first_above 16'hFFFF.
